sync_frame_tx: RTL and testbench

- Serial frame transmitter: the sending end of the 1101 sync-word protocol, whose receive side is the Moore sequence detector.
- Accepts a parallel payload over a valid/ready handshake.
- Serializes it as: sync word 1101, payload MSB-first, even-parity bit, then a zero guard gap.
- Drives a single-bit serial line consumed by the downstream detector/deserializer.

---
 rtl/sync_frame_tx.sv | 147 ++++++++++++++
 tb/tb_sync_frame_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: sync word 1101, payload MSB-first, even parity, zero guard gap.
// Feeds the Moore 1101 sequence detector on the receive side.
module sync_frame_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int GAP_BITS     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  o,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_PRE  = TW'((CLKS_PER_BIT > 1) ? CLKS_PER_BIT - 2 : 0);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_BITS - 1);
  localparam logic [3:0]    SYNC_WORD = 4'b1101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t                  state;
  logic [TW-1:0]           timer;
  logic [1:0]              sync_idx;
  logic [BW-1:0]           bit_cnt;
  logic [GW-1:0]           gap_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    parity;
  logic                    bit_end;

  assign bit_end  = (timer == T_LAST);
  assign tx_ready = (state == IDLE);

  // o always carries the bit for the *next* cycle, so each state loads the
  // following bit at its boundary and the line needs no output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      sync_idx   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      shreg      <= '0;
      parity     <= 1'b0;
      o          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every branch
      // sees the pre-edge values of timer/counters regardless of order.
      frame_done <= 1'b0;
      if (state != IDLE) begin
        timer <= bit_end ? '0 : timer + TW'(1);
      end

      case (state)
        IDLE: begin
          o    <= 1'b0;
          busy <= 1'b0;
          if (tx_valid) begin
            shreg    <= tx_data;
            parity   <= ^tx_data;
            state    <= SYNC;
            timer    <= '0;
            sync_idx <= '0;
            o        <= SYNC_WORD[3];
            busy     <= 1'b1;
          end
        end

        SYNC: begin
          if (bit_end) begin
            if (sync_idx == 2'd3) begin
              state   <= DATA;
              bit_cnt <= '0;
              o       <= shreg[DATA_WIDTH-1];
            end else begin
              sync_idx <= sync_idx + 2'd1;
              o        <= SYNC_WORD[2'd2 - sync_idx];
            end
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt == B_LAST) begin
              state <= PARITY;
              o     <= parity;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg << 1;
              o       <= shreg[DATA_WIDTH-2];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            state      <= GAP;
            gap_cnt    <= '0;
            o          <= 1'b0;
            frame_done <= (GAP_BITS == 1) && (CLKS_PER_BIT == 1);
          end
        end

        GAP: begin
          // frame_done is raised one edge early so the registered pulse lands
          // on the final cycle of the last gap bit.
          if (bit_end) begin
            if (gap_cnt == G_LAST) begin
              state   <= IDLE;
              gap_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              gap_cnt    <= gap_cnt + GW'(1);
              frame_done <= (gap_cnt + GW'(1) == G_LAST) && (CLKS_PER_BIT == 1);
            end
          end else begin
            frame_done <= (gap_cnt == G_LAST) && (timer == T_PRE);
          end
        end

        default: begin
          state <= IDLE;
          timer <= '0;
          o     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Self-checking bench for sync_frame_tx: per-cycle model comparison on two
// instances (1 and 3 clocks per bit) plus hand-computed literal frames.
module tb_sync_frame_tx;

  localparam int FRAME_BITS = 4 + 8 + 1 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tx_valid, tx_ready, o, busy, frame_done;
  logic [7:0] tx_data;
  logic       rst3, tx_valid3, tx_ready3, o3, busy3, frame_done3;
  logic [7:0] tx_data3;

  sync_frame_tx dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .o(o), .busy(busy), .frame_done(frame_done)
  );

  sync_frame_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .GAP_BITS(2)) dut3 (
    .clk(clk), .rst(rst3), .tx_data(tx_data3), .tx_valid(tx_valid3),
    .tx_ready(tx_ready3), .o(o3), .busy(busy3), .frame_done(frame_done3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one entry per busy cycle of a frame, derived from the frame layout.
  typedef struct packed {
    logic o;
    logic fd;
  } cyc_t;

  function automatic cyc_t frame_cycle(input logic [7:0] d, input int c, input int k);
    cyc_t       r;
    logic [3:0] sw;
    int         b;
    sw = 4'b1101;
    b  = k / c;
    if (b < 4)       r.o = sw[3-b];
    else if (b < 12) r.o = d[11-b];
    else if (b == 12) r.o = ^d;
    else             r.o = 1'b0;
    r.fd = (k == FRAME_BITS * c - 1);
    return r;
  endfunction

  cyc_t q1[$];
  cyc_t q3[$];
  logic armed1 = 1'b0;
  logic armed3 = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q1.delete();
      armed1 <= 1'b1;
    end else if (q1.size() > 0) begin
      void'(q1.pop_front());
    end else if (tx_valid) begin
      for (int k = 0; k < FRAME_BITS; k++) q1.push_back(frame_cycle(tx_data, 1, k));
    end
  end

  always @(posedge clk) begin
    if (rst3) begin
      q3.delete();
      armed3 <= 1'b1;
    end else if (q3.size() > 0) begin
      void'(q3.pop_front());
    end else if (tx_valid3) begin
      for (int k = 0; k < FRAME_BITS * 3; k++) q3.push_back(frame_cycle(tx_data3, 3, k));
    end
  end

  always @(negedge clk) begin
    if (armed1) begin
      if (q1.size() > 0) begin
        check("dut1 o", o, q1[0].o);
        check("dut1 busy", busy, 1);
        check("dut1 frame_done", frame_done, q1[0].fd);
        check("dut1 tx_ready", tx_ready, 0);
      end else begin
        check("dut1 idle o", o, 0);
        check("dut1 idle busy", busy, 0);
        check("dut1 idle frame_done", frame_done, 0);
        check("dut1 idle tx_ready", tx_ready, 1);
      end
    end
    if (armed3) begin
      if (q3.size() > 0) begin
        check("dut3 o", o3, q3[0].o);
        check("dut3 busy", busy3, 1);
        check("dut3 frame_done", frame_done3, q3[0].fd);
        check("dut3 tx_ready", tx_ready3, 0);
      end else begin
        check("dut3 idle o", o3, 0);
        check("dut3 idle busy", busy3, 0);
        check("dut3 idle frame_done", frame_done3, 0);
        check("dut3 idle tx_ready", tx_ready3, 1);
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    tx_data  = d;
    tx_valid = 1'b1;
    n = 0;
    while (tx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dut1 accept ready", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] d);
    int n;
    tx_data3  = d;
    tx_valid3 = 1'b1;
    n = 0;
    while (tx_ready3 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("dut3 accept ready", tx_ready3, 1);
    @(negedge clk);
    tx_valid3 = 1'b0;
  endtask

  // Records cycles 1..15 of a frame (MSB = cycle 1) and a 1101 detector view.
  task automatic capture(output logic [14:0] ov, output logic [14:0] fv,
                         output logic [14:0] bv, output logic det4, output logic det5);
    logic [3:0] sh;
    sh = 4'b0000;
    det4 = 1'b0;
    det5 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 4) det4 = (sh == 4'b1101);
      if (k == 5) det5 = (sh == 4'b1101);
      ov[15-k] = o;
      fv[15-k] = frame_done;
      bv[15-k] = busy;
      sh = {sh[2:0], o};
      @(negedge clk);
    end
  endtask

  logic [14:0] ov, fv, bv, bits;
  logic        det4, det5;
  int          s1, s2, fdcnt, fdcyc, bcnt, bad;
  logic        prev_busy;

  initial begin
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
    rst3 = 1'b1; tx_valid3 = 1'b0; tx_data3 = 8'h00;

    // Reset held two cycles with tx_valid high: nothing may be accepted.
    @(negedge clk);
    check("reset o", o, 0);
    check("reset tx_ready", tx_ready, 1);
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    rst = 1'b0; tx_valid = 1'b0;
    @(negedge clk);

    // Single frame 8'hA5.
    send(8'hA5);
    capture(ov, fv, bv, det4, det5);
    check("A5 serial", ov, 15'b110110100101000);
    check("A5 frame_done", fv, 15'b000000000000001);
    check("A5 busy", bv, 15'h7FFF);
    check("A5 cycle16 tx_ready", tx_ready, 1);
    check("A5 cycle16 busy", busy, 0);

    // Parity 1 and detector loopback for 8'h07.
    send(8'h07);
    capture(ov, fv, bv, det4, det5);
    check("07 serial", ov, 15'b110100000111100);
    check("07 parity bit", ov[2], 1);
    check("07 detect before 4th sync", det4, 0);
    check("07 detect after 4th sync", det5, 1);

    // Back-to-back with held valid; data changes mid-frame.
    tx_data = 8'h3C; tx_valid = 1'b1;
    s1 = -1; s2 = -1; prev_busy = busy; ov = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) tx_data = 8'hC3;
      if (busy === 1'b1 && prev_busy === 1'b0) begin
        if (s1 < 0) s1 = k;
        else if (s2 < 0) begin
          s2 = k;
          tx_valid = 1'b0;
        end
      end
      if (s1 >= 0 && s2 < 0 && k - s1 < 15) ov[14-(k-s1)] = o;
      prev_busy = busy;
    end
    check("b2b first start", s1, 1);
    check("b2b start spacing", s2 - s1, 16);
    check("b2b frame1 serial", ov, 15'b110100111100000);

    // Reset during DATA bit 4 of an all-ones payload.
    send(8'hFF);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort o", o, 0);
    check("abort tx_ready", tx_ready, 1);
    check("abort busy", busy, 0);
    check("abort frame_done", frame_done, 0);
    @(negedge clk);
    send(8'h5A);
    capture(ov, fv, bv, det4, det5);
    check("post-abort serial", ov, 15'b110101011010000);
    check("post-abort frame_done", fv, 15'b000000000000001);

    // CLKS_PER_BIT=3 instance, 8'h81.
    rst3 = 1'b0;
    @(negedge clk);
    send3(8'h81);
    bits = 15'b110110000001000;
    fdcnt = 0; fdcyc = 0; bcnt = 0; bad = 0;
    for (int k = 1; k <= 48; k++) begin
      if (k <= 45 && o3 !== bits[14-(k-1)/3]) bad++;
      if (frame_done3 === 1'b1) begin
        fdcnt++;
        fdcyc = k;
      end
      if (busy3 === 1'b1) bcnt++;
      @(negedge clk);
    end
    check("x3 held bit mismatches", bad, 0);
    check("x3 frame_done pulses", fdcnt, 1);
    check("x3 frame_done cycle", fdcyc, 45);
    check("x3 frame length", bcnt, 45);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
